sabana_job_sched: RTL and testbench
===================================

Name: sabana_job_sched

Overview:
- Scheduler placed in front of the 64-entry add kernel (a_in + b[i] -> y[i], start/finish handshake, sticky DONE cleared only by its sync active-high reset).
- Shares one kernel instance between NUM_REQ requesters using round-robin arbitration.
- Per job: clears (re-arms) the kernel, pulses start, waits for finish with an optional timeout, and returns a one-cycle done/err response to the granted requester.
- The grant vector also drives the top-level muxes that route the winner's a_in and RAM ports to the kernel.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- CLR_CYCLES, 2, cycles k_reset is held high before each job (>=1).
- TIMEOUT, 1024, maximum RUN cycles before a job is aborted with err (used only with SCHED_TIMEOUT_EN).

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  level request per requester; held until that requester's done.
- gnt  out  NUM_REQ  one-hot owner of the kernel, held from CLEAR through RESP; 0 otherwise.
- done  out  NUM_REQ  one-cycle pulse to the owner at job end.
- err  out  1  qualifies done: 1 means the job timed out.
- busy  out  1  high in every state except IDLE.
- k_reset  out  1  active-high synchronous reset to the kernel.
- k_start  out  1  one-cycle start pulse to the kernel.
- k_finish  in  1  kernel finish (level, sticky until k_reset).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, gnt=0, done=0, err=0, busy=0, k_start=0, k_reset=1 (kernel held cleared), rr pointer=0, counters=0.
- States and transitions:
  - IDLE: k_reset=1. If any req bit is set, pick the first set bit searching upward from rr pointer with wrap-around; latch its index as owner; next state CLEAR. Otherwise stay in IDLE.
  - CLEAR: gnt=onehot(owner), k_reset=1 for exactly CLR_CYCLES cycles (cycle counter), then START.
  - START: k_reset=0, k_start=1 for exactly one cycle, then RUN.
  - RUN: k_reset=0. k_finish=1 -> RESP with err=0. With SCHED_TIMEOUT_EN, run counter reaching TIMEOUT-1 with no finish -> RESP with err=1. If finish and timeout occur in the same cycle, finish wins (err=0).
  - RESP: done[owner]=1 and err valid for one cycle; gnt still held; k_reset=1; rr pointer <= owner+1 (mod NUM_REQ); next state IDLE.
- Timing: req sampled in IDLE at cycle 0 -> gnt at cycle 1; k_start at cycle CLR_CYCLES+1. The kernel takes 129 cycles from start to finish, so done appears 1 cycle after the first k_finish=1 sample.
- Back-to-back: a new request is granted only from IDLE, giving at least one idle cycle between jobs.
- req deasserted mid-job is ignored: the job completes and done still pulses. A request present in RESP is seen in the following IDLE.
- Only the owner receives done. err=0 whenever done=0.
- k_finish outside RUN is ignored.
- reset asserted mid-job aborts immediately with no done pulse. After reset release, arbitration restarts from rr=0.
- Width rules: owner index is $clog2(NUM_REQ) bits. CLEAR counter is $clog2(CLR_CYCLES+1) bits. RUN counter is $clog2(TIMEOUT) bits and never wraps.

Optional Feature:
- Macro SCHED_TIMEOUT_EN.
- Defined: RUN counter present; timeout aborts the job into RESP with err=1, and the kernel is cleared in the next IDLE/CLEAR.
- Undefined: no counter; RUN waits for k_finish indefinitely; err is tied to 0; TIMEOUT is unused.

Decomposition:
- Package sabana_sched_pkg holds the state enum sched_state_t (IDLE, CLEAR, START, RUN, RESP) and localparam KERNEL_DEPTH=64.
- One sub-module, sabana_rr_arb: combinational round-robin picker (req vector, rr pointer -> valid + index). It is reused by any future multi-requester kernel front-end.

Test Plan:
- Single job: req=2'b01 at cycle 0 -> gnt=01 at cycle 1; k_reset high cycles 1-2; k_start at cycle 3; kernel model finishes at cycle 132 -> done=01, err=0 at cycle 133; gnt=0 at 134.
- Contention: req=2'b11 held -> grants alternate 01,10,01,10 over 4 jobs; each requester gets exactly one done per grant.
- Timeout (SCHED_TIMEOUT_EN, TIMEOUT=16): kernel never finishes -> done pulses with err=1, 16 cycles after entering RUN; next job runs normally after a fresh CLEAR.
- Finish and timeout in the same cycle (k_finish forced at RUN cycle 15, TIMEOUT=16) -> err=0.
- Reset mid-RUN: pull reset low at cycle 50 -> all outputs reach reset values asynchronously, k_reset=1, no done; after release, req=10 is granted first-pass from rr=0.
- req dropped at cycle 10 of a job -> job completes, done still pulses, no new grant follows.

Source files
------------

// File: rtl/sabana_job_sched_pkg.sv
// Shared types for the add-kernel job scheduler: FSM state encoding and kernel geometry.
package sabana_sched_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        CLEAR = ST_CLEAR,
        START = ST_START,
        RUN   = ST_RUN,
        RESP  = ST_RESP
    } sched_state_t;

    localparam int KERNEL_DEPTH = 64;

endpackage

// File: rtl/sabana_job_sched_if.sv
// Requester and kernel handshake bundle of the job scheduler; slave = scheduler side.
interface sabana_job_sched_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] done;
    logic               err;
    logic               busy;
    logic               k_reset;
    logic               k_start;
    logic               k_finish;

    modport slave (
        input  req, k_finish,
        output gnt, done, err, busy, k_reset, k_start
    );

    modport master (
        output req, k_finish,
        input  gnt, done, err, busy, k_reset, k_start
    );
endinterface

// File: rtl/sabana_job_sched_arb.sv
// sabana_rr_arb: combinational round-robin picker; first set req bit at or above ptr, with wrap.
module sabana_rr_arb #(
    parameter int  NUM_REQ = 2,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               valid,
    output logic [IW-1:0]      idx
);
    logic [NUM_REQ-1:0]          rot;
    logic [NUM_REQ-1:0]          first;
    logic [NUM_REQ-1:0][IW-1:0]  cand;
    logic [IW-1:0][NUM_REQ-1:0]  col;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
        localparam logic [NUM_REQ-1:0] LOWER = NUM_REQ'((1 << gi) - 1);
        logic [IW:0] sum;

        // cand[gi] is the requester sitting gi places after the pointer
        assign sum      = {1'b0, ptr} + (IW+1)'(gi);
        assign cand[gi] = (sum >= (IW+1)'(NUM_REQ)) ? IW'(sum - (IW+1)'(NUM_REQ)) : sum[IW-1:0];
        assign rot[gi]  = req[cand[gi]];
        assign first[gi] = rot[gi] && ((rot & LOWER) == '0);
    end

    for (genvar gi = 0; gi < IW; gi++) begin : g_bit
        for (genvar gj = 0; gj < NUM_REQ; gj++) begin : g_src
            assign col[gi][gj] = first[gj] & cand[gj][gi];
        end
        assign idx[gi] = |col[gi];
    end

    assign valid = |req;

endmodule

// File: rtl/sabana_job_sched.sv
// sabana_job_sched: shares one add kernel among NUM_REQ requesters (clear, start, wait, respond).
// Build option SCHED_TIMEOUT_EN adds a RUN watchdog that ends a stuck job with err=1.
module sabana_job_sched
    import sabana_sched_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input logic               clock,
    input logic               reset,
    sabana_job_sched_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(CLR_CYCLES + 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);

    // Illegal configurations elaborate to an empty marker block.
    if (NUM_REQ < 2 || NUM_REQ > 8 || CLR_CYCLES < 1 || TIMEOUT < 2) begin : g_bad_config
    end

    sched_state_t  state_reg, state_next;
    logic [IW-1:0] owner_reg, owner_next;
    logic [IW-1:0] rr_reg, rr_next;
    logic [CW-1:0] clr_cnt_reg, clr_cnt_next;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          timeout_hit;

    sabana_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (bus.req),
        .ptr   (rr_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

`ifdef SCHED_TIMEOUT_EN
    localparam int RW = $clog2(TIMEOUT);
    localparam logic [RW-1:0] RUN_LAST = RW'(TIMEOUT - 1);

    logic [RW-1:0] run_cnt_reg;
    logic          err_reg;

    assign timeout_hit = (run_cnt_reg == RUN_LAST);

    // err_reg tracks why RUN is being left; it is only looked at in RESP
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_cnt_reg <= '0;
            err_reg     <= 1'b0;
        end else if (state_reg == RUN) begin
            if (!timeout_hit) begin
                run_cnt_reg <= run_cnt_reg + 1'b1;
            end
            err_reg <= timeout_hit && !bus.k_finish;
        end else begin
            run_cnt_reg <= '0;
        end
    end

    assign bus.err = (state_reg == RESP) && err_reg;
`else
    assign timeout_hit = 1'b0;
    assign bus.err     = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        rr_next      = rr_reg;
        clr_cnt_next = '0;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    owner_next = pick_idx;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_cnt_reg == CLR_LAST) begin
                    state_next = START;
                end else begin
                    clr_cnt_next = clr_cnt_reg + 1'b1;
                end
            end
            START: state_next = RUN;
            RUN: begin
                // finish takes priority over a coincident timeout
                if (bus.k_finish || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
                rr_next    = (owner_reg == IW'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            owner_reg   <= '0;
            rr_reg      <= '0;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            rr_reg      <= rr_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    logic [NUM_REQ-1:0] gnt_vec;
    logic [NUM_REQ-1:0] done_vec;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_out
        assign gnt_vec[gi]  = (state_reg != IDLE) && (owner_reg == IW'(gi));
        assign done_vec[gi] = (state_reg == RESP) && (owner_reg == IW'(gi));
    end

    assign bus.gnt     = gnt_vec;
    assign bus.done    = done_vec;
    assign bus.busy    = (state_reg != IDLE);
    assign bus.k_reset = (state_reg == IDLE) || (state_reg == CLEAR) || (state_reg == RESP);
    assign bus.k_start = (state_reg == START);

endmodule

// File: tb/tb_sabana_job_sched.sv
// Self-checking bench for sabana_job_sched: kernel model plus a job-level reference model.
`timescale 1ns/1ps
module tb_sabana_job_sched;
  localparam int NR  = 2;
  localparam int CLR = 2;
`ifdef SCHED_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sabana_job_sched_if #(.NUM_REQ(NR)) bus ();

  sabana_job_sched #(.NUM_REQ(NR), .CLR_CYCLES(CLR), .TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int rr_model    = 0;
  int job_no      = 0;

  // Kernel model: finish rises lat cycles after the start cycle and stays up until k_reset.
  int k_lat     = 129;
  int k_age     = 0;
  bit k_run     = 1'b0;
  bit force_fin = 1'b0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      k_run <= 1'b0;
      k_age <= 0;
    end else if (bus.k_reset) begin
      k_run <= 1'b0;
      k_age <= 0;
    end else if (bus.k_start) begin
      k_run <= 1'b1;
      k_age <= 1;
    end else if (k_run && k_age < 100000) begin
      k_age <= k_age + 1;
    end
  end

  assign bus.k_finish = (k_run && (k_age >= k_lat)) || force_fin;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [NR-1:0] onehot(input int i);
    logic [NR-1:0] v;
    v = {{(NR-1){1'b0}}, 1'b1};
    return v << i;
  endfunction

  function automatic int ref_pick(input logic [NR-1:0] m);
    logic [NR-1:0] sh;
    for (int k = 0; k < NR; k++) begin
      int i;
      i  = (rr_model + k) % NR;
      sh = m >> i;
      if (sh[0]) return i;
    end
    return -1;
  endfunction

  function automatic int exp_run_len(input int lat);
`ifdef SCHED_TIMEOUT_EN
    return (lat <= TO) ? lat : TO;
`else
    return lat;
`endif
  endfunction

  function automatic bit exp_err_of(input int lat);
`ifdef SCHED_TIMEOUT_EN
    return lat > TO;
`else
    return 1'b0;
`endif
  endfunction

  // Runs one job from an IDLE negedge; returns at the negedge of the IDLE cycle after RESP.
  task automatic do_job(input logic [NR-1:0] mask, input int lat, input int drop_at);
    int owner, start_off, done_off, want_done;
    bit exp_err, gnt_bad, kr_bad, err_bad;
    logic [NR-1:0] want_gnt, seen_done;
    logic seen_err;
    logic [2*NR+1:0] tail;
    owner     = ref_pick(mask);
    want_gnt  = onehot(owner);
    exp_err   = exp_err_of(lat);
    want_done = CLR + 2 + exp_run_len(lat);
    bus.req   = mask;
    k_lat     = lat;
    start_off = -1; done_off = -1;
    gnt_bad = 0; kr_bad = 0; err_bad = 0;
    seen_done = '0; seen_err = 1'b0;
    for (int n = 1; n <= want_done + 20 && done_off < 0; n++) begin
      @(negedge clock);
      if (n == drop_at) bus.req = '0;
      if (bus.gnt !== want_gnt) gnt_bad = 1;
      if (bus.done !== '0) begin
        done_off  = n;
        seen_done = bus.done;
        seen_err  = bus.err;
        if (bus.k_reset !== 1'b1) kr_bad = 1;
      end else begin
        if (bus.err !== 1'b0) err_bad = 1;
        if (bus.k_start === 1'b1) begin
          if (start_off >= 0) kr_bad = 1;
          start_off = n;
        end
        if (bus.k_reset !== ((start_off < 0) ? 1'b1 : 1'b0)) kr_bad = 1;
      end
    end
    vectors++; if (gnt_bad) begin miscompares++; $display("FAIL job%0d gnt_held: got unstable want %b", job_no, want_gnt); end
    vectors++; if (kr_bad) begin miscompares++; $display("FAIL job%0d k_reset_shape: got bad want clear-start-run-resp", job_no); end
    vectors++; if (start_off != CLR + 1) begin miscompares++; $display("FAIL job%0d start_offset: got %0d want %0d", job_no, start_off, CLR + 1); end
    vectors++; if (done_off != want_done) begin miscompares++; $display("FAIL job%0d done_offset: got %0d want %0d", job_no, done_off, want_done); end
    vectors++; if (seen_done !== want_gnt) begin miscompares++; $display("FAIL job%0d done_vec: got %b want %b", job_no, seen_done, want_gnt); end
    vectors++; if (seen_err !== exp_err) begin miscompares++; $display("FAIL job%0d err: got %b want %b", job_no, seen_err, exp_err); end
    vectors++; if (err_bad) begin miscompares++; $display("FAIL job%0d err_without_done: got 1 want 0", job_no); end
    @(negedge clock);
    tail = {bus.gnt, bus.done, bus.busy, bus.err};
    vectors++; if (tail !== '0) begin miscompares++; $display("FAIL job%0d idle_after: got %b want 0", job_no, tail); end
    $display("job %0d: req=%b owner=%0d lat=%0d start@%0d done@%0d err=%b", job_no, mask, owner, lat, start_off, done_off, seen_err);
    rr_model = (owner + 1) % NR;
    job_no++;
  endtask

  task automatic test_reset();
    logic [2*NR+3:0] obs, want;
    want = '0; want[0] = 1'b1;
    bus.req = '0;
    #1 reset = 1'b0;
    #3;
    obs = {bus.gnt, bus.done, bus.err, bus.busy, bus.k_start, bus.k_reset};
    vectors++; if (obs !== want) begin miscompares++; $display("FAIL reset_async: got %b want %b", obs, want); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    obs = {bus.gnt, bus.done, bus.err, bus.busy, bus.k_start, bus.k_reset};
    vectors++; if (obs !== want) begin miscompares++; $display("FAIL reset_idle: got %b want %b", obs, want); end
    rr_model = 0;
  endtask

  task automatic test_single_job();
    do_job(2'b01, 129, -1);
    bus.req = '0;
  endtask

  task automatic test_contention();
    for (int j = 0; j < 4; j++) do_job(2'b11, 129, -1);
    bus.req = '0;
  endtask

  task automatic test_req_drop();
    bit stray;
    do_job(2'b01, 129, 10);
    stray = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (bus.gnt !== '0 || bus.busy !== 1'b0) stray = 1;
    end
    vectors++; if (stray) begin miscompares++; $display("FAIL req_drop_no_regrant: got grant want none"); end
  endtask

  task automatic test_finish_outside_run();
    bit bad;
    bus.req = '0;
    force_fin = 1'b1;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if ({bus.gnt, bus.done, bus.busy, bus.err} !== '0) bad = 1;
    end
    force_fin = 1'b0;
    vectors++; if (bad) begin miscompares++; $display("FAIL finish_in_idle: got activity want idle"); end
  endtask

`ifdef SCHED_TIMEOUT_EN
  task automatic test_timeout();
    do_job(2'b10, 1000, -1);
    do_job(2'b01, 10, -1);
    do_job(2'b10, TO, -1);
    do_job(2'b01, TO + 1, -1);
    bus.req = '0;
  endtask
`endif

  task automatic test_reset_mid_run();
    logic [2*NR+3:0] obs, want;
    bit bad;
    do_job(2'b01, 20, -1);
    bus.req = 2'b01;
    k_lat = 129;
    repeat (50) @(negedge clock);
    vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("FAIL midrun_owner: got %b want 01", bus.gnt); end
    #2 reset = 1'b0;
    bus.req = '0;
    #1;
    want = '0; want[0] = 1'b1;
    obs = {bus.gnt, bus.done, bus.err, bus.busy, bus.k_start, bus.k_reset};
    vectors++; if (obs !== want) begin miscompares++; $display("FAIL midrun_reset_async: got %b want %b", obs, want); end
    bad = 0;
    repeat (3) begin
      @(negedge clock);
      if (bus.done !== '0) bad = 1;
    end
    vectors++; if (bad) begin miscompares++; $display("FAIL midrun_no_done: got pulse want none"); end
    reset = 1'b1;
    rr_model = 0;
    do_job(2'b11, 40, -1);
    bus.req = '0;
  endtask

  task automatic test_random();
    logic [NR-1:0] mask;
    int lat, gap;
    for (int j = 0; j < 12; j++) begin
      mask = NR'($urandom_range((1 << NR) - 1, 1));
`ifdef SCHED_TIMEOUT_EN
      lat = int'($urandom_range(TO + 8, 1));
`else
      lat = int'($urandom_range(150, 1));
`endif
      do_job(mask, lat, -1);
      gap = int'($urandom_range(3, 0));
      if (gap != 0) begin
        bus.req = '0;
        repeat (gap) @(negedge clock);
      end
    end
    bus.req = '0;
  endtask

  initial begin
    bus.req = '0;
    test_reset();
    test_single_job();
    test_contention();
    test_req_drop();
    test_finish_outside_run();
`ifdef SCHED_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
